// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures the decoded instruction bundle for EX, inserts bubbles for
// load-use hazards and redirects, honours the global cache stall, and keeps
// a saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic [3:0]       id_funct_i,
  input  logic [9:0]       id_ctrl_i,
  output logic             hazard_stall_o,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [3:0]       ex_funct_o,
  output logic [9:0]       ex_ctrl_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam int MEMREAD_BIT = 6;

  logic flush_pend;
  logic hazard_raw;
  logic eff_flush;
  logic rs_match;

  // The rs2 compare is deliberately unconditional: an instruction without rs2
  // may stall needlessly, but a real dependency is never missed.
  assign rs_match   = (ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i);
  assign hazard_raw = ex_valid_o & ex_ctrl_o[MEMREAD_BIT] & (ex_rd_o != 5'd0)
                    & id_valid_i & rs_match;

  // A redirect already kills the ID instruction, so no hold is needed then.
  assign hazard_stall_o = hazard_raw & ~flush_i & ~flush_pend;
  assign eff_flush      = flush_i | flush_pend;

  // Remember a redirect that arrived while frozen so it is applied on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else if (stall_i) begin
      if (flush_i) begin
        flush_pend <= 1'b1;
      end
    end else begin
      flush_pend <= 1'b0;
    end
  end

  // Pipeline register: hold on stall, bubble on redirect or load-use, else load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_funct_o    <= '0;
      ex_ctrl_o     <= '0;
    end else if (stall_i) begin
      ex_valid_o    <= ex_valid_o;
    end else if (eff_flush | hazard_raw) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_funct_o    <= '0;
      ex_ctrl_o     <= '0;
    end else begin
      ex_valid_o    <= id_valid_i;
      ex_pc_o       <= id_pc_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_rs1_o      <= id_rs1_i;
      ex_rs2_o      <= id_rs2_i;
      ex_rd_o       <= id_rd_i;
      ex_funct_o    <= id_funct_i;
      ex_ctrl_o     <= id_valid_i ? id_ctrl_i : 10'd0;
    end
  end

  // Count load-use bubbles only; redirect bubbles are not hazards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
    end else if (!stall_i && !eff_flush && hazard_raw && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, compared against a behavioural model of the EX-side register.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall_i, flush_i, id_valid_i;
  logic [XLEN-1:0]  id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i;
  logic [3:0]       id_funct_i;
  logic [9:0]       id_ctrl_i;

  logic             hazard_stall_o, ex_valid_o;
  logic [XLEN-1:0]  ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]       ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0]       ex_funct_o;
  logic [9:0]       ex_ctrl_o;
  logic [15:0]      bubble_cnt_o;

  logic             s_hazard_stall, s_ex_valid;
  logic [XLEN-1:0]  s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]       s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [3:0]       s_ex_funct;
  logic [9:0]       s_ex_ctrl;
  logic [1:0]       s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model of what EX should hold
  logic             m_valid;
  logic [XLEN-1:0]  m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]       m_rs1, m_rs2, m_rd;
  logic [3:0]       m_funct;
  logic [9:0]       m_ctrl;
  bit               m_pend;
  int               m_cnt, m_cnt_sat;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct_i(id_funct_i), .id_ctrl_i(id_ctrl_i),
    .hazard_stall_o(hazard_stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
    .ex_ctrl_o(ex_ctrl_o), .bubble_cnt_o(bubble_cnt_o));

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct_i(id_funct_i), .id_ctrl_i(id_ctrl_i),
    .hazard_stall_o(s_hazard_stall), .ex_valid_o(s_ex_valid), .ex_pc_o(s_ex_pc),
    .ex_rs1_data_o(s_ex_rs1_data), .ex_rs2_data_o(s_ex_rs2_data), .ex_imm_o(s_ex_imm),
    .ex_rs1_o(s_ex_rs1), .ex_rs2_o(s_ex_rs2), .ex_rd_o(s_ex_rd), .ex_funct_o(s_ex_funct),
    .ex_ctrl_o(s_ex_ctrl), .bubble_cnt_o(s_bubble_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A load in EX whose destination is read by the ID instruction
  function automatic bit model_load_use();
    return m_valid && m_ctrl[6] && (m_rd != 5'd0) && id_valid_i &&
           ((m_rd == id_rs1_i) || (m_rd == id_rs2_i));
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_funct = '0; m_ctrl = '0;
  endtask

  task automatic model_clock();
    bit eff, lu;
    if (!rst_n) begin
      model_bubble();
      m_pend = 1'b0; m_cnt = 0; m_cnt_sat = 0;
    end else if (stall_i) begin
      if (flush_i) m_pend = 1'b1;
    end else begin
      eff = flush_i || m_pend;
      lu  = model_load_use();
      m_pend = 1'b0;
      if (eff) begin
        model_bubble();
      end else if (lu) begin
        model_bubble();
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end else begin
        m_valid = id_valid_i; m_pc = id_pc_i; m_rs1d = id_rs1_data_i;
        m_rs2d = id_rs2_data_i; m_imm = id_imm_i; m_rs1 = id_rs1_i;
        m_rs2 = id_rs2_i; m_rd = id_rd_i; m_funct = id_funct_i;
        m_ctrl = id_valid_i ? id_ctrl_i : 10'd0;
      end
    end
  endtask

  function automatic bit model_hazard_stall();
    return model_load_use() && !flush_i && !m_pend;
  endfunction

  task automatic checkOutput();
    check("ex_valid",    32'(ex_valid_o),    32'(m_valid));
    check("ex_pc",       ex_pc_o,            m_pc);
    check("ex_rs1_data", ex_rs1_data_o,      m_rs1d);
    check("ex_rs2_data", ex_rs2_data_o,      m_rs2d);
    check("ex_imm",      ex_imm_o,           m_imm);
    check("ex_rs1",      32'(ex_rs1_o),      32'(m_rs1));
    check("ex_rs2",      32'(ex_rs2_o),      32'(m_rs2));
    check("ex_rd",       32'(ex_rd_o),       32'(m_rd));
    check("ex_funct",    32'(ex_funct_o),    32'(m_funct));
    check("ex_ctrl",     32'(ex_ctrl_o),     32'(m_ctrl));
    check("bubble_cnt",  32'(bubble_cnt_o),  32'(m_cnt));
    check("sat_valid",   32'(s_ex_valid),    32'(m_valid));
    check("sat_ctrl",    32'(s_ex_ctrl),     32'(m_ctrl));
    check("sat_cnt",     32'(s_bubble_cnt),  32'(m_cnt_sat));
  endtask

  // Drive one cycle of inputs, check the combinational hold, clock, check EX.
  task automatic applyStimulus(input bit rst, input bit stall, input bit flush,
                               input bit valid, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [9:0] ctrl);
    rst_n = ~rst; stall_i = stall; flush_i = flush; id_valid_i = valid;
    id_pc_i = pc; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_ctrl_i = ctrl;
    id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
    id_funct_i = 4'($urandom);
    #1;
    check("hazard_stall",     32'(hazard_stall_o), 32'(model_hazard_stall()));
    check("sat_hazard_stall", 32'(s_hazard_stall), 32'(model_hazard_stall()));
    @(posedge clk);
    model_clock();
    #1;
    checkOutput();
  endtask

  localparam logic [9:0] CTRL_R  = 10'b0000000100;
  localparam logic [9:0] CTRL_LW = 10'h0F6;

  int sat_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset with a fully-asserted control bundle on the inputs
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b1;
    id_pc_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0;
    id_rs1_i = 5'd1; id_rs2_i = 5'd2; id_rd_i = 5'd3; id_funct_i = '0; id_ctrl_i = 10'h3FF;
    model_bubble(); m_pend = 1'b0; m_cnt = 0; m_cnt_sat = 0;
    @(posedge clk); #1;
    applyStimulus(1, 0, 0, 1, 32'h0, 5'd1, 5'd2, 5'd3, 10'h3FF);
    check("reset_valid", 32'(ex_valid_o), 32'd0);
    check("reset_cnt",   32'(bubble_cnt_o), 32'd0);

    // Plain R-type flow
    applyStimulus(0, 0, 0, 1, 32'h40, 5'd1, 5'd2, 5'd5, CTRL_R);
    check("plain_pc",   ex_pc_o, 32'h40);
    check("plain_ctrl", 32'(ex_ctrl_o), 32'h004);

    // Load-use: lw x7, then add reading x7 via rs2
    applyStimulus(0, 0, 0, 1, 32'h44, 5'd2, 5'd3, 5'd7, CTRL_LW);
    applyStimulus(0, 0, 0, 1, 32'h48, 5'd1, 5'd7, 5'd8, CTRL_R);
    check("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
    check("lu_bubble_cnt",   32'(bubble_cnt_o), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h48, 5'd1, 5'd7, 5'd8, CTRL_R);
    check("lu_after_pc", ex_pc_o, 32'h48);

    // Load to x0 never stalls
    applyStimulus(0, 0, 0, 1, 32'h4C, 5'd2, 5'd3, 5'd0, CTRL_LW);
    applyStimulus(0, 0, 0, 1, 32'h50, 5'd0, 5'd0, 5'd9, CTRL_R);
    check("x0_cnt", 32'(bubble_cnt_o), 32'd1);

    // Redirect arriving during a 3-cycle freeze is applied on release
    applyStimulus(0, 1, 1, 1, 32'h54, 5'd1, 5'd2, 5'd3, CTRL_R);
    applyStimulus(0, 1, 0, 1, 32'h54, 5'd1, 5'd2, 5'd3, CTRL_R);
    applyStimulus(0, 1, 0, 1, 32'h54, 5'd1, 5'd2, 5'd3, CTRL_R);
    check("stall_hold_pc", ex_pc_o, 32'h50);
    applyStimulus(0, 0, 0, 1, 32'h54, 5'd1, 5'd2, 5'd3, CTRL_R);
    check("pend_bubble", 32'(ex_valid_o), 32'd0);
    applyStimulus(0, 0, 0, 1, 32'h58, 5'd1, 5'd2, 5'd3, CTRL_R);
    check("pend_after_pc", ex_pc_o, 32'h58);

    // Redirect and load-use together: redirect wins, no count
    applyStimulus(0, 0, 0, 1, 32'h5C, 5'd2, 5'd3, 5'd7, CTRL_LW);
    applyStimulus(0, 0, 1, 1, 32'h60, 5'd1, 5'd7, 5'd8, CTRL_R);
    check("flush_hz_cnt", 32'(bubble_cnt_o), 32'd1);

    // Saturation of the 2-bit counter over five load-use bubbles
    applyStimulus(1, 0, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 10'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h100 + 32'(8*i), 5'd2, 5'd3, 5'd7, CTRL_LW);
      applyStimulus(0, 0, 0, 1, 32'h104 + 32'(8*i), 5'd7, 5'd1, 5'd8, CTRL_R);
      check("sat_seq", 32'(s_bubble_cnt), 32'(sat_seq[i]));
    end
    check("wide_cnt_5", 32'(bubble_cnt_o), 32'd5);

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                    $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 10'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
